mem_bus_master: RTL and testbench

- Initiator side of the asynchronous sEP8 memory bus: turns single-cycle transfer commands from the processor core into timed sequences on a23_a0, s_, mr_, mw_, d7_d0.
- Sits between the processor datapath and the RAM/ROM/IO responders.
- Supports 1-4 byte little-endian transfers with automatic address increment; setup, strobe and hold timing is counted in clock cycles.

---
 rtl/mem_bus_master.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_master.sv
// Initiator for the asynchronous sEP8 memory bus: runs 1-4 byte little-endian
// transfers as timed SETUP / STROBE / HOLD sequences with registered bus outputs.
module mem_bus_master #(
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 2,
  parameter int T_HOLD   = 1
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_len,
  input  logic [23:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ack,
  output logic [31:0] cmd_rdata,
  output logic        busy,
  output logic [23:0] a23_a0,
  output logic        s_,
  output logic        mr_,
  output logic        mw_,
  inout  wire  [7:0]  d7_d0
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [1:0]  idx, idx_nx;
  logic        wr_q;
  logic [1:0]  len_q;
  logic [23:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  dout;
  logic        oe;

  logic        accept;
  logic        sample_rd;
  logic        wr_eff;
  logic [23:0] base_addr;
  logic [31:0] wdata_eff;
  logic        on_bus_nx;
  logic        s_nx, mr_nx, mw_nx, oe_nx;
  logic [23:0] a_nx;
  logic [7:0]  dout_nx;

  assign accept    = (state == IDLE) && cmd_req;
  assign sample_rd = (state == STROBE) && (cnt == 4'(T_STROBE - 1)) && !wr_q;

  // The first SETUP cycle's outputs are registered at the accepting edge, so
  // they must come from the command inputs rather than the not-yet-latched copy.
  assign wr_eff    = accept ? cmd_wr    : wr_q;
  assign base_addr = accept ? cmd_addr  : addr_q;
  assign wdata_eff = accept ? cmd_wdata : wdata_q;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (cmd_req) begin
          state_nx = SETUP;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      end
      SETUP: begin
        if (cnt == 4'(T_SETUP - 1)) begin
          state_nx = STROBE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'(T_STROBE - 1)) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'(T_HOLD - 1)) begin
          cnt_nx = '0;
          if (idx < len_q) begin
            idx_nx   = idx + 2'd1;
            state_nx = SETUP;
          end else begin
            state_nx = DONE;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are derived from the next state and registered with it.
  always_comb begin
    on_bus_nx = (state_nx == SETUP) || (state_nx == STROBE) || (state_nx == HOLD);
    s_nx      = !on_bus_nx;
    mr_nx     = !((state_nx == STROBE) && !wr_eff);
    mw_nx     = !((state_nx == STROBE) && wr_eff);
    oe_nx     = on_bus_nx && wr_eff;
    a_nx      = on_bus_nx ? (base_addr + 24'(idx_nx)) : a23_a0;
    dout_nx   = wdata_eff[{idx_nx, 3'b000} +: 8];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      wr_q      <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cmd_ack   <= 1'b0;
      cmd_rdata <= '0;
      busy      <= 1'b0;
      a23_a0    <= '0;
      s_        <= 1'b1;
      mr_       <= 1'b1;
      mw_       <= 1'b1;
      oe        <= 1'b0;
      dout      <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      cmd_ack <= (state_nx == DONE);
      busy    <= (state_nx != IDLE);
      a23_a0  <= a_nx;
      s_      <= s_nx;
      mr_     <= mr_nx;
      mw_     <= mw_nx;
      oe      <= oe_nx;
      dout    <= dout_nx;
      if (accept) begin
        wr_q      <= cmd_wr;
        len_q     <= cmd_len;
        addr_q    <= cmd_addr;
        wdata_q   <= cmd_wdata;
        cmd_rdata <= '0;
      end else if (sample_rd) begin
        cmd_rdata[{idx, 3'b000} +: 8] <= d7_d0;
      end
    end
  end

  assign d7_d0 = oe ? dout : 8'bz;

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master: two instances (default and slow timing)
// on modelled RAM buses, with a per-instance bus monitor and ack checker.
module tb_mem_bus_master;

  localparam int TSU [2] = '{1, 2};
  localparam int TST [2] = '{2, 3};
  localparam int THO [2] = '{1, 2};

  typedef struct {
    logic [31:0] rdata;
    int          ack_cyc;
    int          s_cnt;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_;
  logic        cmd_req   [2];
  logic        cmd_wr    [2];
  logic [1:0]  cmd_len   [2];
  logic [23:0] cmd_addr  [2];
  logic [31:0] cmd_wdata [2];
  logic        cmd_ack   [2];
  logic [31:0] cmd_rdata [2];
  logic        busy      [2];
  logic [23:0] a_bus     [2];
  logic        s_n       [2];
  logic        mr_n      [2];
  logic        mw_n      [2];

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;
  int viol   = 0;

  logic [7:0]  ram [logic [23:0]];
  exp_t        exp_q  [2][$];
  logic [23:0] addr_q [2][$];

  function automatic logic [7:0] ram_rd(input logic [23:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    wire  [7:0] d;
    logic [7:0] rd_byte = 8'h00;
    int         low_w = 0;
    int         s_cnt = 0;
    logic       prev_act = 1'b0;
    logic       act;
    exp_t       e;

    for (genvar b = 0; b < 8; b++) begin : g_pu
      pullup (d[b]);
    end

    assign d = (!mr_n[g] && !s_n[g]) ? rd_byte : 8'bz;

    mem_bus_master #(.T_SETUP(TSU[g]), .T_STROBE(TST[g]), .T_HOLD(THO[g])) dut (
      .clock     (clock),
      .reset_    (reset_),
      .cmd_req   (cmd_req[g]),
      .cmd_wr    (cmd_wr[g]),
      .cmd_len   (cmd_len[g]),
      .cmd_addr  (cmd_addr[g]),
      .cmd_wdata (cmd_wdata[g]),
      .cmd_ack   (cmd_ack[g]),
      .cmd_rdata (cmd_rdata[g]),
      .busy      (busy[g]),
      .a23_a0    (a_bus[g]),
      .s_        (s_n[g]),
      .mr_       (mr_n[g]),
      .mw_       (mw_n[g]),
      .d7_d0     (d)
    );

    always @(negedge clock) begin
      rd_byte = ram_rd(a_bus[g]);
      if (!reset_) begin
        low_w    = 0;
        s_cnt    = 0;
        prev_act = 1'b0;
      end else begin
        if (!mr_n[g] && !mw_n[g]) viol++;
        if ((!mr_n[g] || !mw_n[g]) && s_n[g]) viol++;
        if (!mw_n[g] && !s_n[g]) ram[a_bus[g]] = d;
        if (!s_n[g]) s_cnt++;
        act = !(mr_n[g] && mw_n[g]);
        if (act && !prev_act) begin
          check("strobe_expected", 32'(addr_q[g].size() != 0), 32'd1);
          if (addr_q[g].size() != 0) check("strobe_addr", 32'(a_bus[g]), 32'(addr_q[g].pop_front()));
        end
        if (act) low_w++;
        else if (prev_act) begin
          check("strobe_width", low_w, TST[g]);
          low_w = 0;
        end
        prev_act = act;
        if (cmd_ack[g]) begin
          check("ack_expected", 32'(exp_q[g].size() != 0), 32'd1);
          if (exp_q[g].size() != 0) begin
            e = exp_q[g].pop_front();
            check("ack_rdata", cmd_rdata[g], e.rdata);
            check("ack_cycle", cyc, e.ack_cyc);
            check("sel_low_cycles", s_cnt, e.s_cnt);
          end
          s_cnt = 0;
        end
      end
    end
  end

  // Called just after a rising edge; the command is accepted at the next edge.
  task automatic issue(input int g, input logic wr, input logic [1:0] len,
                       input logic [23:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd);
    exp_t e;
    int   p;
    p = TSU[g] + TST[g] + THO[g];
    for (int i = 0; i <= int'(len); i++) addr_q[g].push_back(addr + 24'(i));
    e.rdata   = exp_rd;
    e.ack_cyc = cyc + 1 + (int'(len) + 1) * p;
    e.s_cnt   = (int'(len) + 1) * p;
    exp_q[g].push_back(e);
    cmd_req[g]   = 1'b1;
    cmd_wr[g]    = wr;
    cmd_len[g]   = len;
    cmd_addr[g]  = addr;
    cmd_wdata[g] = wdata;
    @(posedge clock); #1;
    cmd_req[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n;
    n = 0;
    while (busy[g] && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("idle_within_budget", 32'(busy[g]), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, "_s"},     32'(s_n[0]),  32'd1);
    check({tag, "_mr"},    32'(mr_n[0]), 32'd1);
    check({tag, "_mw"},    32'(mw_n[0]), 32'd1);
    check({tag, "_busy"},  32'(busy[0]), 32'd0);
    check({tag, "_ack"},   32'(cmd_ack[0]), 32'd0);
    check({tag, "_bus_released"}, 32'(g_inst[0].d), 32'hFF);
  endtask

  initial begin
    int n;
    for (int g = 0; g < 2; g++) begin
      cmd_req[g] = 1'b0; cmd_wr[g] = 1'b0; cmd_len[g] = '0;
      cmd_addr[g] = '0; cmd_wdata[g] = '0;
    end
    ram[24'h000010] = 8'hA5;
    ram[24'hFFFFFE] = 8'hC1;
    ram[24'hFFFFFF] = 8'hB2;
    ram[24'h000000] = 8'hA3;
    ram[24'h000001] = 8'h94;

    reset_ = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_idle_bus("reset");
    check("reset_addr",  32'(a_bus[0]), 32'h0);
    check("reset_rdata", cmd_rdata[0], 32'h0);
    @(posedge clock); #1;
    reset_ = 1'b1;
    @(posedge clock); #1;

    // Single-byte read with default timing.
    issue(0, 1'b0, 2'd0, 24'h000010, 32'h0, 32'h0000_00A5);
    wait_idle(0);

    // Three-byte write, then read it back; the unused top byte must read 0.
    issue(0, 1'b1, 2'd2, 24'h001000, 32'h0033_2211, 32'h0);
    wait_idle(0);
    check("ram_1000", 32'(ram_rd(24'h001000)), 32'h11);
    check("ram_1001", 32'(ram_rd(24'h001001)), 32'h22);
    check("ram_1002", 32'(ram_rd(24'h001002)), 32'h33);
    check("ram_1003_untouched", 32'(ram.exists(24'h001003)), 32'd0);
    issue(0, 1'b0, 2'd2, 24'h001000, 32'h0, 32'h0033_2211);
    wait_idle(0);

    // Four-byte read wrapping past the top of the address space.
    issue(0, 1'b0, 2'd3, 24'hFFFFFE, 32'h0, 32'h94A3_B2C1);
    wait_idle(0);

    // Requests while busy and in the DONE cycle are dropped.
    issue(0, 1'b0, 2'd0, 24'h000010, 32'h0, 32'h0000_00A5);
    @(posedge clock); #1;
    cmd_req[0] = 1'b1; cmd_addr[0] = 24'h000020;
    @(posedge clock); #1;
    cmd_req[0] = 1'b0;
    n = 0;
    while (!cmd_ack[0] && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    check("ack_seen_for_drop_test", 32'(cmd_ack[0]), 32'd1);
    cmd_req[0] = 1'b1;
    @(posedge clock); #1;
    cmd_req[0] = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check("drop_no_busy", 32'(busy[0]), 32'd0);

    // Slow-timing instance: 3-cycle strobe, 7 cycles per byte.
    issue(1, 1'b0, 2'd0, 24'h000010, 32'h0, 32'h0000_00A5);
    wait_idle(1);

    // Reset held for two edges during a strobe aborts the transfer.
    issue(0, 1'b0, 2'd1, 24'h000010, 32'h0, 32'h0);
    n = 0;
    while (mr_n[0] && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("strobe_reached_before_reset", 32'(mr_n[0]), 32'd0);
    reset_ = 1'b0;
    exp_q[0].delete();
    addr_q[0].delete();
    repeat (2) @(posedge clock);
    #1;
    reset_ = 1'b1;
    @(negedge clock);
    check_idle_bus("abort");
    repeat (5) @(posedge clock);
    #1;
    check("abort_still_idle", 32'(busy[0]), 32'd0);

    check("bus_rules", viol, 0);
    check("nothing_pending", exp_q[0].size() + exp_q[1].size() + addr_q[0].size() + addr_q[1].size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
